small_mem: RTL and testbench

Small synchronous register-file memory: 4 entries × 10 bits, one write port and one read port, single clock.
Stores per-slot LED/position patterns for the arcade game datapath. Downstream display logic reads them.
Writes and reads are independent and may target different or the same address in the same cycle.

---
 rtl/small_mem.sv | 72 +++++++
 tb/tb_small_mem.sv | 134 +++++++++++++
 2 files changed

// File: rtl/small_mem.sv
`default_nettype none
// ============================================================================
//  Module   : small_mem
//  Purpose  : Small synchronous register-file memory holding the per-slot
//             LED/position patterns for the arcade game datapath. It has one
//             write port and one read port on a single clock. The read port
//             is registered, so read data appears one cycle after the address.
//
//  Ports    : clk          in   1       system clock, rising-edge active
//             rst_n        in   1       synchronous active-low reset
//             write_enable in   1       write strobe
//             addr_wr      in   ADDR_W  write address
//             data_in      in   DATA_W  write data
//             addr_rd      in   ADDR_W  read address
//             data_out     out  DATA_W  registered read data
//
//  Options  : SMALL_MEM_BYPASS_EN
//               defined   - write-through bypass. A same-address write in
//                           the same cycle as a read returns the new data.
//               undefined - read-before-write. A same-address collision
//                           returns the old stored data.
//
//  Revision : 1.0  initial release
// ============================================================================
module small_mem #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_rd,
  output logic [DATA_W-1:0] data_out
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic [DATA_W-1:0] w_rd_data;

`ifdef SMALL_MEM_BYPASS_EN
  // Forward the incoming write data when it targets the address being read.
  assign w_rd_data = (write_enable && (addr_wr == addr_rd)) ? data_in : r_mem[addr_rd];
`else
  // The read sees the stored contents from before this edge, so a
  // same-address write only becomes visible on the following read.
  assign w_rd_data = r_mem[addr_rd];
`endif

  // Reset clears the whole array. It takes priority over any write in the
  // same cycle, so that write is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_data_out <= '0;
    end else begin
      if (write_enable) begin
        r_mem[addr_wr] <= data_in;
      end
      r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_small_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_small_mem
//  Purpose  : Directed self-checking bench for small_mem. The expected values
//             are computed by hand. Each check is an immediate assertion.
//             Inputs change 1 time unit after each rising edge, and outputs
//             are sampled at the same point.
//  Revision : 1.0  initial release
// ============================================================================
module tb_small_mem;

  logic       clk;
  logic       rst_n;
  logic       write_enable;
  logic [1:0] addr_wr;
  logic [9:0] data_in;
  logic [1:0] addr_rd;
  logic [9:0] data_out;

  int total;
  int bad;

  small_mem #(.DATA_W(10), .ADDR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .addr_wr      (addr_wr),
    .data_in      (data_in),
    .addr_rd      (addr_rd),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
    end
  endtask

  logic [9:0] wr_vals [4];

  initial begin
    total = 0;
    bad   = 0;
    wr_vals[0] = 10'h002;
    wr_vals[1] = 10'h008;
    wr_vals[2] = 10'h020;
    wr_vals[3] = 10'h100;

    // Reset held for 2 cycles while a write is being attempted.
    rst_n = 1'b0; write_enable = 1'b1; addr_wr = 2'd0; data_in = 10'h3FF; addr_rd = 2'd0;
    step();
    step();
    check("reset_dout", data_out, 10'h000);

    rst_n = 1'b1; write_enable = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr_rd = 2'(a);
      step();
      check($sformatf("reset_rd%0d", a), data_out, 10'h000);
    end

    // Each write is a 1-cycle pulse, followed by an idle cycle.
    addr_rd = 2'd0;
    for (int a = 0; a < 4; a++) begin
      write_enable = 1'b1; addr_wr = 2'(a); data_in = wr_vals[a];
      step();
      write_enable = 1'b0;
      step();
    end
    for (int a = 0; a < 4; a++) begin
      addr_rd = 2'(a);
      step();
      check($sformatf("seq_rd%0d", a), data_out, wr_vals[a]);
    end

    // With write_enable low, the presented write does not change addr1.
    addr_wr = 2'd1; data_in = 10'h155; write_enable = 1'b0; addr_rd = 2'd0;
    step();
    addr_rd = 2'd1;
    step();
    check("we_gate", data_out, 10'h008);

    // Same-address read and write in the same cycle.
    addr_wr = 2'd0; data_in = 10'h0AA; write_enable = 1'b1; addr_rd = 2'd0;
    step();
`ifdef SMALL_MEM_BYPASS_EN
    check("collide_edge1", data_out, 10'h0AA);
`else
    check("collide_edge1", data_out, 10'h002);
`endif
    write_enable = 1'b0;
    step();
    check("collide_edge2", data_out, 10'h0AA);

    // Three back-to-back writes to addr2; the last one should be kept.
    addr_rd = 2'd0; write_enable = 1'b1; addr_wr = 2'd2;
    data_in = 10'h001; step();
    data_in = 10'h002; step();
    data_in = 10'h3FF; step();
    write_enable = 1'b0; addr_rd = 2'd2;
    step();
    check("b2b_rd2", data_out, 10'h3FF);

    // Confirm addr3 is loaded, then reset in the middle of a write to it.
    addr_rd = 2'd3;
    step();
    check("pre_rst_rd3", data_out, 10'h100);
    rst_n = 1'b0; write_enable = 1'b1; addr_wr = 2'd3; data_in = 10'h200;
    step();
    check("midrst_dout", data_out, 10'h000);
    rst_n = 1'b1; write_enable = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr_rd = 2'(a);
      step();
      check($sformatf("midrst_rd%0d", a), data_out, 10'h000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
